mmc_wb_master: RTL and testbench
================================

// Module: mmc_wb_master
// PURPOSE
//   Wishbone initiator that drives the 8-bit MMC controller register slave (3-bit address).
//   Turns host requests into single or burst Wishbone transfers. A burst repeats one address,
//   typically the data register streamed with auto-advance. Sits between the host bridge and
//   the MMC controller slave. Returns read data and a completion or error status per beat.
// PARAMETERS
//   TIMEOUT_CYCLES  1024  max cycles stb may wait for ack before the beat is aborted
//   TO_W            11    width of the timeout counter (must hold TIMEOUT_CYCLES)
// PORTS
//   wb_clk_i     in   1  clock
//   wb_rst_n_i   in   1  reset, synchronous, active-low
//   req_valid    in   1  host request valid
//   req_ready    out  1  request accepted when req_valid & req_ready
//   req_we       in   1  1 = write burst, 0 = read burst
//   req_adr      in   3  register address, constant for the whole burst
//   req_len      in   8  beats minus one (0 = 1 beat, 255 = 256 beats)
//   wr_valid     in   1  write-data beat valid
//   wr_ready     out  1  write data taken when wr_valid & wr_ready
//   wr_dat       in   8  write-data beat
//   rsp_valid    out  1  one-cycle pulse per completed or aborted beat; no backpressure
//   rsp_dat      out  8  read data (0x00 for writes)
//   rsp_last     out  1  final beat of the burst (also set on abort)
//   rsp_err      out  1  beat aborted by timeout
//   busy         out  1  burst in progress
//   wb_cyc_o     out  1  Wishbone cycle
//   wb_stb_o     out  1  Wishbone strobe
//   wb_we_o      out  1  Wishbone write enable
//   wb_adr_o     out  3  Wishbone address
//   wb_dat_o     out  8  Wishbone write data
//   wb_dat_i     in   8  Wishbone read data
//   wb_ack_i     in   1  Wishbone acknowledge
// BEHAVIOUR
//   Reset: all outputs 0, except req_ready=1 in IDLE. Counters are cleared and the FSM enters IDLE.
//   A reset mid-burst drops cyc/stb on the next edge and emits no rsp.
//   FSM states: IDLE, FETCH, STROBE, GAP.
//     IDLE:   req_ready=1. On accept, latch we/adr/len, set beat_cnt=len and wb_cyc_o=1.
//             Go to FETCH if we=1, else to STROBE.
//     FETCH:  wr_ready=1. On wr_valid, latch wr_dat into wb_dat_o, then go to STROBE.
//             cyc is held high and stb is low while waiting.
//     STROBE: stb=1, with we/adr/dat stable.
//             On the edge where ack=1: deassert stb, capture wb_dat_i into rsp_dat (reads),
//             pulse rsp_valid next cycle, and go to GAP.
//     GAP:    exactly one cycle with stb=0 and ack ignored. The slave registers ack and re-samples
//             stb on the ack edge, so one trailing ack pulse is expected and must be dropped.
//             If beat_cnt==0: rsp_last=1, cyc=0, go to IDLE.
//             Otherwise: beat_cnt-=1, go to FETCH (write) or STROBE (read).
//   Latency: the slave acks one cycle after stb, and longer while its memory-advance is pending.
//     Minimum read beat is 3 cycles (STROBE, ACK, GAP); minimum write beat is 4 (FETCH added).
//   Any ack seen outside STROBE is ignored.
//   req_valid is ignored while busy; a new request may be accepted in the cycle after the
//   final GAP.
//   beat_cnt is 8 bits: len=255 gives 256 beats with no wrap. The counter never underflows
//   because it is tested for 0 before decrementing.
//   rsp_valid and rsp_last for the final beat are asserted in the same cycle; busy falls
//   one cycle later.
// CONFIGURATION
//   MMC_WBM_TIMEOUT_EN defined:
//     A counter runs while in STROBE and clears on entry to STROBE.
//     When it reaches TIMEOUT_CYCLES-1 without ack: drop stb and cyc, then pulse rsp_valid
//     with rsp_err=1, rsp_last=1, rsp_dat=0x00. The remaining beats are discarded and the
//     FSM returns to IDLE. In FETCH, wr_valid is not needed after an abort.
//   MMC_WBM_TIMEOUT_EN undefined:
//     No counter is built. STROBE waits for ack indefinitely, rsp_err is tied to 0,
//     and TIMEOUT_CYCLES and TO_W are unused.
// TESTING
//   1. Single write adr=4, dat=0x23, slave acks 1 cycle after stb
//      -> one 2-cycle stb with we=1, adr=4, dat=0x23; rsp_valid & rsp_last, rsp_err=0; busy falls.
//   2. Read burst adr=1, len=3, slave returns 0xA0..0xA3
//      -> four stb pulses separated by 1-cycle gaps; rsp_dat A0,A1,A2,A3; rsp_last only on 4th;
//         cyc high throughout.
//   3. Slave holds ack low 20 cycles on beat 2 of a read burst with len=1
//      -> stb held 20+ cycles; trailing ack in GAP ignored; exactly 2 rsp pulses.
//   4. Write burst len=2 with wr_valid withheld 5 cycles before beat 2
//      -> cyc stays 1, stb stays 0 during the wait; wb_dat_o follows wr_dat beats.
//   5. MMC_WBM_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never arrives
//      -> stb drops after 16 cycles; rsp_err=1, rsp_last=1; req_ready=1 next cycle.
//   6. Assert wb_rst_n_i low during STROBE of a 4-beat read
//      -> cyc/stb=0 after the edge, no rsp_valid; a fresh request then completes normally.

Source files
------------

// File: rtl/mmc_wb_master.sv
`default_nettype none
// ============================================================================
// mmc_wb_master : Wishbone initiator for the 8-bit MMC register slave.
// Optional beat timeout is built when MMC_WBM_TIMEOUT_EN is defined.  Rev 1.0
// ============================================================================
module mmc_wb_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_adr,
  input  logic [7:0] req_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_dat,
  output logic       rsp_valid,
  output logic [7:0] rsp_dat,
  output logic       rsp_last,
  output logic       rsp_err,
  output logic       busy,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STROBE = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_cyc;
  logic       r_we;
  logic [2:0] r_adr;
  logic [7:0] r_dat;
  logic [7:0] r_cnt;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_dat;
  logic       r_rsp_last;
  logic       r_rsp_err;
  logic       w_accept;
  logic       w_ack_hit;
  logic       w_timeout;

  assign w_accept  = req_valid & (r_state == S_IDLE);
  assign w_ack_hit = wb_ack_i & (r_state == S_STROBE);

`ifdef MMC_WBM_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  // Held at zero outside STROBE so every strobe starts counting from zero.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i || (r_state != S_STROBE)) r_to_cnt <= '0;
    else                                      r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_STROBE) & ~wb_ack_i &
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES > TO_W);
  assign w_timeout   = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    wb_stb_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = req_we ? S_FETCH : S_STROBE;
      end
      S_FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) w_next = S_STROBE;
      end
      S_STROBE: begin
        wb_stb_o = 1'b1;
        if (wb_ack_i)       w_next = S_GAP;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_GAP: begin
        // The slave's trailing ack lands here and is deliberately not looked at.
        if (r_cnt == 8'd0) w_next = S_IDLE;
        else               w_next = r_we ? S_FETCH : S_STROBE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= 3'd0;
      r_dat       <= 8'd0;
      r_cnt       <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= 8'd0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      if (w_accept) begin
        r_cyc <= 1'b1;
        r_we  <= req_we;
        r_adr <= req_adr;
        r_cnt <= req_len;
      end
      if ((r_state == S_FETCH) && wr_valid) r_dat <= wr_dat;
      if (w_ack_hit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_dat   <= r_we ? 8'h00 : wb_dat_i;
        r_rsp_last  <= (r_cnt == 8'd0);
      end else if (w_timeout) begin
        r_cyc       <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_dat   <= 8'h00;
        r_rsp_last  <= 1'b1;
        r_rsp_err   <= 1'b1;
      end
      if (r_state == S_GAP) begin
        if (r_cnt == 8'd0) r_cyc <= 1'b0;
        else               r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign wb_cyc_o  = r_cyc;
  assign wb_we_o   = r_we;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_last  = r_rsp_last;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_mmc_wb_master.sv
`default_nettype none
// tb_mmc_wb_master : randomized bench for mmc_wb_master against a queue-based
// beat model and a registered-ack Wishbone slave.
module tb_mmc_wb_master;

  localparam int TB_TO = 16;
`ifdef MMC_WBM_TIMEOUT_EN
  localparam int DLY3 = 12;
`else
  localparam int DLY3 = 19;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [2:0] req_adr = 3'd0;
  logic [7:0] req_len = 8'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_dat = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_dat;
  logic       rsp_last;
  logic       rsp_err;
  logic       busy;
  logic       cyc;
  logic       stb;
  logic       we;
  logic [2:0] adr;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack;

  mmc_wb_master #(.TIMEOUT_CYCLES(TB_TO), .TO_W(5)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_dat    (wr_dat),
    .rsp_valid (rsp_valid),
    .rsp_dat   (rsp_dat),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .wb_cyc_o  (cyc),
    .wb_stb_o  (stb),
    .wb_we_o   (we),
    .wb_adr_o  (adr),
    .wb_dat_o  (dat_o),
    .wb_dat_i  (dat_i),
    .wb_ack_i  (ack)
  );

  always #5 clk = ~clk;

  // Slave: ack is registered from stb after a per-beat delay, so one trailing ack follows each beat.
  logic [7:0] rd_data [0:256];
  logic [7:0] wdat    [0:256];
  int         slv_dly [0:256];
  int         slv_idx;
  int         slv_cnt;

  always @(posedge clk) begin
    if (!rst_n || !cyc)  slv_idx <= 0;
    else if (stb && ack) slv_idx <= slv_idx + 1;
    if (!rst_n || !stb) begin
      slv_cnt <= 0;
      ack     <= 1'b0;
    end else begin
      ack     <= (slv_cnt >= slv_dly[slv_idx]);
      slv_cnt <= slv_cnt + 1;
    end
  end
  assign dat_i = rd_data[slv_idx];

  typedef struct packed {logic [7:0] dat; logic last; logic err;} rsp_t;
  typedef struct packed {logic we; logic [2:0] adr; logic [7:0] dat;} bus_t;
  rsp_t rsp_q[$];
  bus_t bus_q[$];
  int   stb_runs[$];
  int   gap_runs[$];
  int   run_hi;
  int   run_lo;
  int   viol = 0;
  logic prev_last;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      run_hi    <= 0;
      run_lo    <= 0;
      prev_last <= 1'b0;
    end else begin
      if (rsp_valid) rsp_q.push_back({rsp_dat, rsp_last, rsp_err});
      if (cyc && stb && ack) bus_q.push_back({we, adr, dat_o});
      if (stb) begin
        run_hi <= run_hi + 1;
        if (run_lo > 0) gap_runs.push_back(run_lo);
        run_lo <= 0;
      end else begin
        if (run_hi > 0) stb_runs.push_back(run_hi);
        run_hi <= 0;
        run_lo <= cyc ? run_lo + 1 : 0;
      end
`ifdef MMC_WBM_TIMEOUT_EN
      viol <= viol + int'(stb && !cyc) + int'(cyc !== busy) + int'(prev_last && busy);
`else
      viol <= viol + int'(stb && !cyc) + int'(cyc !== busy) + int'(prev_last && busy) +
              int'(rsp_valid && !busy);
`endif
      prev_last <= rsp_valid && rsp_last;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_defaults(input int dmax);
    for (int i = 0; i <= 256; i++) begin
      rd_data[i] = 8'($urandom);
      wdat[i]    = 8'($urandom);
      slv_dly[i] = $urandom_range(0, dmax);
    end
  endtask

  task automatic clear_logs();
    rsp_q.delete();
    bus_q.delete();
    stb_runs.delete();
    gap_runs.delete();
  endtask

  task automatic run_burst(input logic bwe, input logic [2:0] badr, input logic [7:0] blen,
                           input int maxgap, input int gap_beat, input int gap_len);
    int n;
    int g;
    int t;
    n = int'(blen) + 1;
    clear_logs();
    check("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = bwe; req_adr = badr; req_len = blen;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_adr = 3'($urandom); req_len = 8'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    if (bwe) begin
      for (int i = 0; i < n; i++) begin
        t = 0;
        while (!wr_ready && t < 5000) begin @(negedge clk); t++; end
        check("wr_ready_seen", 32'(wr_ready), 32'd1);
        if (t >= 5000) break;
        g = (i == gap_beat) ? gap_len : $urandom_range(0, maxgap);
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          if (i == gap_beat) check("fetch_hold_cyc_stb", 32'({cyc, stb}), 32'b10);
        end
        wr_valid = 1'b1; wr_dat = wdat[i];
        @(negedge clk);
        wr_valid = 1'b0; wr_dat = 8'($urandom);
      end
    end
    t = 0;
    while (busy && t < 20000) begin @(negedge clk); t++; end
    check("busy_falls", 32'(busy), 32'd0);
    check("rsp_count", 32'(rsp_q.size()), 32'(n));
    for (int i = 0; i < n && i < rsp_q.size(); i++)
      check("rsp_beat", 32'(rsp_q[i]), 32'({bwe ? 8'h00 : rd_data[i], (i == n - 1), 1'b0}));
    check("bus_count", 32'(bus_q.size()), 32'(n));
    for (int i = 0; i < n && i < bus_q.size(); i++) begin
      check("bus_we_adr", 32'({bus_q[i].we, bus_q[i].adr}), 32'({bwe, badr}));
      if (bwe) check("bus_wdat", 32'(bus_q[i].dat), 32'(wdat[i]));
    end
    check("stb_count", 32'(stb_runs.size()), 32'(n));
    for (int i = 0; i < n && i < stb_runs.size(); i++)
      check("stb_len", 32'(stb_runs[i]), 32'(slv_dly[i] + 2));
    if (!bwe) begin
      check("gap_count", 32'(gap_runs.size()), 32'(n - 1));
      for (int i = 0; i < gap_runs.size(); i++) check("gap_len", 32'(gap_runs[i]), 32'd1);
    end
    check("protocol", 32'(viol), 32'd0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs",
          32'({cyc, stb, we, adr, dat_o, rsp_valid, rsp_dat, rsp_last, rsp_err, busy, wr_ready}),
          32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, immediate ack.
    set_defaults(0);
    wdat[0] = 8'h23;
    run_burst(1'b1, 3'd4, 8'd0, 0, -1, 0);

    // Four-beat read returning A0..A3.
    set_defaults(0);
    for (int i = 0; i < 4; i++) rd_data[i] = 8'hA0 + 8'(i);
    run_burst(1'b0, 3'd1, 8'd3, 0, -1, 0);

    // Slow ack on the second beat of a two-beat read.
    set_defaults(0);
    slv_dly[1] = DLY3;
    run_burst(1'b0, 3'd2, 8'd1, 0, -1, 0);

    // Write burst with write data withheld before beat 2.
    set_defaults(0);
    run_burst(1'b1, 3'd6, 8'd2, 0, 1, 5);

`ifdef MMC_WBM_TIMEOUT_EN
    set_defaults(0);
    for (int i = 0; i <= 256; i++) slv_dly[i] = 100000;
    clear_logs();
    req_valid = 1'b1; req_we = 1'b0; req_adr = 3'd3; req_len = 8'd3;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    check("to_rsp", 32'({rsp_valid, rsp_dat, rsp_last, rsp_err}), 32'({1'b1, 8'h00, 1'b1, 1'b1}));
    check("to_ready", 32'(req_ready), 32'd1);
    check("to_cyc_stb", 32'({cyc, stb}), 32'd0);
    @(negedge clk);
    check("to_stb_runs", 32'(stb_runs.size()), 32'd1);
    if (stb_runs.size() > 0) check("to_stb_len", 32'(stb_runs[0]), 32'(TB_TO));
    check("to_rsp_count", 32'(rsp_q.size()), 32'd1);
`endif

    // Reset asserted while a four-beat read is waiting on ack.
    set_defaults(0);
    slv_dly[1] = 10;
    clear_logs();
    req_valid = 1'b1; req_we = 1'b0; req_adr = 3'd2; req_len = 8'd3;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (bus_q.size() < 1 && t < 100) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    check("pre_rst_stb", 32'(stb), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", 32'({cyc, stb, rsp_valid, busy, req_ready}), 32'b00001);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_rsp_count", 32'(rsp_q.size()), 32'd1);
    set_defaults(1);
    run_burst(1'b0, 3'd2, 8'd3, 0, -1, 0);

    // Randomized bursts.
    for (int r = 0; r < 8; r++) begin
      set_defaults(3);
      run_burst(1'($urandom), 3'($urandom), 8'($urandom_range(0, 15)), 3, -1, 0);
    end

    // Full-length bursts (len=255).
    set_defaults(1);
    run_burst(1'b0, 3'd5, 8'd255, 0, -1, 0);
    set_defaults(0);
    run_burst(1'b1, 3'd7, 8'd255, 1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
